// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM state type
// and the default datapath width.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_exec_mul_seq.sv
// Iterative shift-add unsigned multiplier, one iteration per clock.
// o_done/o_product describe the iteration completing on the coming edge.
module mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

    logic                 r_active;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic                 w_last;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
    end

    assign w_last    = r_active && (r_cnt == CW'(MUL_CYCLES - 1));
    assign o_done    = w_last;
    assign o_product = w_prod_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_prod   <= {{WIDTH{1'b0}}, i_b};
        end else if (r_active) begin
            r_prod <= w_prod_nxt;
            if (w_last) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith ops, 32-cycle iterative MULT,
// valid/ready handshake on both sides with a one-entry result register.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_xfer;
    logic                 w_is_mult;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]     w_alu;

    assign in_ready  = (r_state == IDLE) && (!out_valid || out_ready);
    assign w_xfer    = in_valid && in_ready;
    assign w_is_mult = (op == OP_MULT);
    assign busy      = (r_state == MUL);

    always_comb begin
        w_alu = '0;
        case (op)
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_alu = '0;
        endcase
    end

    mul_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_xfer && w_is_mult),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_xfer && w_is_mult) w_state_nxt = MUL;
            MUL:     if (w_mul_done)          w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // A new result (MULT completion or single-cycle op) wins over draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
        end else if (w_mul_done) begin
            hi        <= w_product[2*WIDTH-1:WIDTH];
            lo        <= w_product[WIDTH-1:0];
            result    <= w_product[WIDTH-1:0];
            zero      <= (w_product[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
        end else if (w_xfer && !w_is_mult) begin
            result    <= w_alu;
            zero      <= (w_alu == '0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: behavioural model compared every cycle,
// directed literal cases plus randomized traffic with backpressure.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    alu_exec #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model: a multiply is "edges remaining" plus the arithmetic product.
    logic        m_mul;
    int          m_left;
    logic [63:0] m_prod;
    logic        m_ov;
    logic        m_zero;
    logic [31:0] m_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mul  <= 1'b0;
            m_left <= 0;
            m_prod <= '0;
            m_ov   <= 1'b0;
            m_zero <= 1'b0;
            m_res  <= '0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_mul) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_mul  <= 1'b0;
                m_hi   <= m_prod[63:32];
                m_lo   <= m_prod[31:0];
                m_res  <= m_prod[31:0];
                m_zero <= (m_prod[31:0] == 32'd0);
                m_ov   <= 1'b1;
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
        end else if (in_valid && (!m_ov || out_ready)) begin
            if (op == 4'b1000) begin
                m_mul  <= 1'b1;
                m_left <= 32;
                m_prod <= 64'(a) * 64'(b);
                if (out_ready) m_ov <= 1'b0;
            end else begin
                m_res  <= ref_alu(op, a, b);
                m_zero <= (ref_alu(op, a, b) == 32'd0);
                m_ov   <= 1'b1;
            end
        end else if (out_ready) begin
            m_ov <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("result",    result,    m_res);
            check("zero",      zero,      m_zero);
            check("hi",        hi,        m_hi);
            check("lo",        lo,        m_lo);
            check("busy",      busy,      m_mul);
            check("in_ready",  in_ready,  !m_mul && (!m_ov || out_ready));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result",    result,    32'd0);
        check("rst_hilo",      {hi, lo},  64'd0);
        @(posedge clk);
        #1;

        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_result", result,    32'd0);
        check("add_wrap_zero",   zero,      1'b1);
        check("add_wrap_valid",  out_valid, 1'b1);

        issue(4'b0110, 32'd5, 32'd7);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_zero",   zero,   1'b0);
        issue(4'b0111, 32'hFFFF_FFFE, 32'd1);
        check("slt_neg_lt", result, 32'd1);
        issue(4'b0111, 32'd1, 32'hFFFF_FFFE);
        check("slt_pos_ge", result, 32'd0);
        issue(4'b0101, 32'd3, 32'd4);
        check("undef_result", result,    32'd0);
        check("undef_zero",   zero,      1'b1);
        check("undef_valid",  out_valid, 1'b1);

        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        op       = 4'b0010;
        a        = 32'd7;
        b        = 32'd8;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k < 32) begin
                check("mul_wait_valid", out_valid, 1'b0);
                check("mul_wait_busy",  busy,      1'b1);
                check("mul_wait_ready", in_ready,  1'b0);
            end else begin
                check("mul_done_valid", out_valid, 1'b1);
                check("mul_hi",         hi,        32'hFFFF_FFFE);
                check("mul_lo",         lo,        32'h0000_0001);
                check("mul_result",     result,    32'h0000_0001);
                check("mul_done_busy",  busy,      1'b0);
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(4'b0010, 32'd10, 32'd20);
        check("bp_first_result", result,    32'd30);
        check("bp_first_valid",  out_valid, 1'b1);
        in_valid = 1'b1;
        op       = 4'b0001;
        a        = 32'h0000_00F0;
        b        = 32'h0000_000F;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_ready",  in_ready,  1'b0);
            check("bp_hold_result", result,    32'd30);
            check("bp_hold_valid",  out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("bp_swap_result", result,    32'h0000_00FF);
        check("bp_swap_valid",  out_valid, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        issue(4'b1000, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_result", result,    32'd0);
        check("abort_zero",   zero,      1'b0);
        check("abort_hi",     hi,        32'd0);
        check("abort_lo",     lo,        32'd0);
        check("abort_valid",  out_valid, 1'b0);
        check("abort_busy",   busy,      1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_abort_ready", in_ready, 1'b1);
        check("post_abort_hilo",  {hi, lo}, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: op = 4'b0000;
                1: op = 4'b0001;
                2: op = 4'b0010;
                3: op = 4'b0110;
                4: op = 4'b0111;
                5: op = 4'b1000;
                default: op = 4'($urandom);
            endcase
            a = pick_operand();
            b = pick_operand();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
